clint_timer: RTL and testbench
==============================

// Module: clint_timer
// PURPOSE
//  Core-local interruptor feeding ex_csr's tmr_irq_i/sft_irq_i. Holds the 64-bit mtime counter, the mtimecmp
//  compare register and the msip software-interrupt bit. All three are reachable over a single-master
//  request/ack register port from the load/store unit.
// PARAMETERS
//  MTIME_DIV   1       clk cycles per mtime tick (>=1); 1 = tick every cycle
//  OFS_MSIP    16'h0000  byte offset of msip (bit0 = msip, bits 63:1 read 0, write ignored)
//  OFS_CMP     16'h4000  byte offset of mtimecmp
//  OFS_MTIME   16'hBFF8  byte offset of mtime
// PORTS
//  clk         in   1   core clock
//  rst         in   1   synchronous, active-high reset
//  req_i       in   1   register access request (held until ack_o)
//  we_i        in   1   1=write, 0=read; sampled with req_i
//  addr_i      in   16  byte offset within CLINT window
//  wdata_i     in   64  write data (full 64-bit write only)
//  ack_o       out  1   one-cycle completion pulse
//  err_o       out  1   valid with ack_o; 1 = unmapped/misaligned offset
//  rdata_o     out  64  read data, valid with ack_o
//  tmr_irq_o   out  1   timer interrupt pending -> ex_csr tmr_irq_i
//  sft_irq_o   out  1   software interrupt pending -> ex_csr sft_irq_i
//  halt_i      in   1   freeze mtime (present only with CLINT_TIMER_HALT_EN)
// BEHAVIOUR
//  Reset (rst=1 at posedge): mtime=0, prescaler=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip=0,
//   state=IDLE, ack_o=0, err_o=0, rdata_o=0, tmr_irq_o=0, sft_irq_o=0. rst mid-access aborts it: no ack, no write.
//  FSM IDLE->RESP->IDLE:
//   - IDLE & req_i: decode addr_i, perform the write at this edge, latch read data/err, go to RESP.
//   - RESP: ack_o=1 for exactly one cycle. Return to IDLE.
//   - Latency: req_i seen at edge N -> ack_o high during cycle N+1.
//   - Master drops req_i in cycle N+1 (ack cycle). A req_i still high in IDLE after ack is a new access.
//   - req_i is ignored while in RESP.
//  Decode:
//   - addr_i[2:0]!=0 or offset not in {OFS_MSIP, OFS_CMP, OFS_MTIME} -> err_o=1, rdata_o=0, no state change.
//   - Otherwise err_o=0.
//   - rdata_o holds its value until the next ack.
//  mtime:
//   - The prescaler counts 0..MTIME_DIV-1; mtime += 1 on the cycle the prescaler wraps.
//   - mtime wraps from 64'hFFFF_FFFF_FFFF_FFFF to 0.
//   - A write to mtime in the same cycle as a tick wins: mtime=wdata_i, no increment, prescaler reset to 0.
//   - A read returns mtime as of the request-accept edge (pre-increment value).
//  tmr_irq_o: registered (mtime >= mtimecmp), unsigned 64-bit compare, updated every cycle.
//   - Appears 1 cycle after the compare becomes true.
//   - Writing mtimecmp above mtime clears it 1 cycle after the write edge.
//  sft_irq_o: registered copy of msip[0], 1 cycle after the write edge.
//  No partial-width writes; 32-bit halves are not separately addressable.
// CONFIGURATION
//  CLINT_TIMER_HALT_EN defined:
//   - Port halt_i exists; while halt_i=1, the prescaler and mtime hold.
//   - A software write to mtime still takes effect.
//   - Compare and register access continue normally.
//  CLINT_TIMER_HALT_EN undefined: no halt_i port; mtime runs unconditionally.
// TESTING
//  1 Reset, MTIME_DIV=1, no access for 10 cycles -> mtime read = 10 (+ access latency), tmr_irq_o=0, sft_irq_o=0.
//  2 Write mtimecmp=64'd20 at mtime=5 -> tmr_irq_o rises exactly one cycle after mtime reaches 20.
//    Then write mtimecmp=64'd1000 -> tmr_irq_o=0 next cycle.
//  3 Write msip=64'h3 -> sft_irq_o=1 next cycle, msip read=64'h1. Write 0 -> sft_irq_o=0.
//  4 Write mtime=64'hFFFF_FFFF_FFFF_FFFE, mtimecmp=all-ones -> irq asserts at all-ones.
//    mtime then wraps to 0 and irq clears one cycle later.
//  5 Read offset 16'h0004 and 16'h1000 -> ack_o with err_o=1, rdata_o=0, no register changes.
//    Also assert back-to-back req_i -> ack every other cycle.
//  6 MTIME_DIV=4 with CLINT_TIMER_HALT_EN: mtime +1 per 4 cycles.
//    halt_i=1 for 8 cycles -> mtime unchanged. rst asserted in RESP -> no ack, all regs at reset values.

Source files
------------

// File: rtl/clint_timer.sv
// Core-local interruptor: 64-bit mtime with prescaler, mtimecmp and msip on a request/ack register port.
// Optional mtime freeze input halt_i is enabled by defining CLINT_TIMER_HALT_EN.
module clint_timer #(
  parameter int unsigned MTIME_DIV = 1,
  parameter logic [15:0] OFS_MSIP  = 16'h0000,
  parameter logic [15:0] OFS_CMP   = 16'h4000,
  parameter logic [15:0] OFS_MTIME = 16'hBFF8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [15:0] addr_i,
  input  logic [63:0] wdata_i,
`ifdef CLINT_TIMER_HALT_EN
  input  logic        halt_i,
`endif
  output logic        ack_o,
  output logic        err_o,
  output logic [63:0] rdata_o,
  output logic        tmr_irq_o,
  output logic        sft_irq_o
);

  localparam int unsigned   PW        = (MTIME_DIV > 1) ? $clog2(MTIME_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(MTIME_DIV - 1);

  typedef enum logic {
    S_IDLE,
    S_RESP
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [63:0]   mtime_q, mtime_d;
  logic [63:0]   mtimecmp_q, mtimecmp_d;
  logic          msip_q, msip_d;
  logic [63:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          tmr_irq_q, sft_irq_q;

  logic run, tick, aligned, sel_msip, sel_cmp, sel_mtime, hit;

`ifdef CLINT_TIMER_HALT_EN
  assign run = ~halt_i;
`else
  assign run = 1'b1;
`endif

  assign tick      = run && (presc_q == PRESC_MAX);
  assign aligned   = (addr_i[2:0] == 3'b000);
  assign sel_msip  = aligned && (addr_i == OFS_MSIP);
  assign sel_cmp   = aligned && (addr_i == OFS_CMP);
  assign sel_mtime = aligned && (addr_i == OFS_MTIME);
  assign hit       = sel_msip || sel_cmp || sel_mtime;

  always_comb begin
    // NOTE: every next-state value gets a default first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    presc_d    = presc_q;
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    rdata_d    = rdata_q;
    err_d      = err_q;

    if (run) presc_d = tick ? '0 : presc_q + PW'(1);
    if (tick) mtime_d = mtime_q + 64'd1;

    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          state_d = S_RESP;
          err_d   = ~hit;
          rdata_d = '0;
          if (hit && !we_i) begin
            if (sel_msip)  rdata_d = {63'd0, msip_q};
            if (sel_cmp)   rdata_d = mtimecmp_q;
            if (sel_mtime) rdata_d = mtime_q;
          end
          if (hit && we_i) begin
            if (sel_msip) msip_d     = wdata_i[0];
            if (sel_cmp)  mtimecmp_d = wdata_i;
            // A software write to mtime overrides any tick in the same cycle and restarts the prescaler.
            if (sel_mtime) begin
              mtime_d = wdata_i;
              presc_d = '0;
            end
          end
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      state_q    <= S_IDLE;
      presc_q    <= '0;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      msip_q     <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      tmr_irq_q  <= 1'b0;
      sft_irq_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      tmr_irq_q  <= (mtime_q >= mtimecmp_q);
      sft_irq_q  <= msip_q;
    end
  end

  assign ack_o     = (state_q == S_RESP);
  assign err_o     = err_q;
  assign rdata_o   = rdata_q;
  assign tmr_irq_o = tmr_irq_q;
  assign sft_irq_o = sft_irq_q;

endmodule

// File: tb/tb_clint_timer.sv
// Directed bench for clint_timer: instance a runs MTIME_DIV=1, instance b runs MTIME_DIV=4
// (halt_i exercised on b when CLINT_TIMER_HALT_EN is defined).
module tb_clint_timer;

  localparam logic [15:0] A_MSIP  = 16'h0000;
  localparam logic [15:0] A_CMP   = 16'h4000;
  localparam logic [15:0] A_MTIME = 16'hBFF8;
  localparam logic [63:0] ONES    = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        req_a = 1'b0, we_a = 1'b0;
  logic [15:0] addr_a = '0;
  logic [63:0] wdata_a = '0;
  logic        ack_a, err_a, tmr_a, sft_a;
  logic [63:0] rdata_a;

  logic        req_b = 1'b0, we_b = 1'b0;
  logic [15:0] addr_b = '0;
  logic [63:0] wdata_b = '0;
  logic        ack_b, err_b, tmr_b, sft_b;
  logic [63:0] rdata_b;

`ifdef CLINT_TIMER_HALT_EN
  logic        halt_a = 1'b0;
  logic        halt_b = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] rd;
  logic        er;

  always #5 clk = ~clk;

  clint_timer #(.MTIME_DIV(1)) dut_a (
    .clk      (clk),
    .rst      (rst),
    .req_i    (req_a),
    .we_i     (we_a),
    .addr_i   (addr_a),
    .wdata_i  (wdata_a),
`ifdef CLINT_TIMER_HALT_EN
    .halt_i   (halt_a),
`endif
    .ack_o    (ack_a),
    .err_o    (err_a),
    .rdata_o  (rdata_a),
    .tmr_irq_o(tmr_a),
    .sft_irq_o(sft_a)
  );

  clint_timer #(.MTIME_DIV(4)) dut_b (
    .clk      (clk),
    .rst      (rst),
    .req_i    (req_b),
    .we_i     (we_b),
    .addr_i   (addr_b),
    .wdata_i  (wdata_b),
`ifdef CLINT_TIMER_HALT_EN
    .halt_i   (halt_b),
`endif
    .ack_o    (ack_b),
    .err_o    (err_b),
    .rdata_o  (rdata_b),
    .tmr_irq_o(tmr_b),
    .sft_irq_o(sft_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one access from an IDLE cycle; returns during the ack cycle with req_i dropped.
  task automatic access(input bit sel_b, input logic we, input logic [15:0] addr,
                        input logic [63:0] wd, output logic [63:0] rdo, output logic ero);
    if (sel_b) begin
      req_b = 1'b1; we_b = we; addr_b = addr; wdata_b = wd;
    end else begin
      req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = wd;
    end
    step();
    chk("ack_latency", sel_b ? ack_b : ack_a, 1'b1);
    rdo = sel_b ? rdata_b : rdata_a;
    ero = sel_b ? err_b : err_a;
    req_a = 1'b0;
    req_b = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  initial begin
    // 1: reset state, then free-running mtime
    repeat (3) step();
    rst = 1'b0;
    chk("rst_ack", ack_a, 1'b0);
    chk("rst_err", err_a, 1'b0);
    chk("rst_rdata", rdata_a, 64'd0);
    chk("rst_tmr", tmr_a, 1'b0);
    chk("rst_sft", sft_a, 1'b0);
    repeat (10) step();
    access(0, 0, A_MTIME, 0, rd, er);
    chk("mtime_after_10", rd, 64'd10);
    chk("mtime_read_err", er, 1'b0);
    chk("idle_tmr", tmr_a, 1'b0);
    chk("idle_sft", sft_a, 1'b0);
    step();

    // 2: timer compare rise and clear
    access(0, 1, A_CMP, 64'd20, rd, er);
    step();
    access(0, 1, A_MTIME, 64'd5, rd, er);
    step();
    repeat (14) step();
    chk("tmr_at_mtime20", tmr_a, 1'b0);
    step();
    chk("tmr_one_after", tmr_a, 1'b1);
    access(0, 1, A_CMP, 64'd1000, rd, er);
    chk("tmr_write_edge", tmr_a, 1'b1);
    step();
    chk("tmr_cleared", tmr_a, 1'b0);

    // 3: software interrupt
    access(0, 1, A_MSIP, 64'h3, rd, er);
    chk("sft_write_edge", sft_a, 1'b0);
    step();
    chk("sft_set", sft_a, 1'b1);
    access(0, 0, A_MSIP, 0, rd, er);
    chk("msip_read", rd, 64'h1);
    step();
    access(0, 1, A_MSIP, 64'h0, rd, er);
    step();
    chk("sft_clear", sft_a, 1'b0);

    // 4: mtime wrap around all-ones compare
    access(0, 1, A_CMP, ONES, rd, er);
    step();
    access(0, 1, A_MTIME, 64'hFFFF_FFFF_FFFF_FFFE, rd, er);
    step();
    chk("wrap_tmr_fe", tmr_a, 1'b0);
    step();
    chk("wrap_tmr_ff", tmr_a, 1'b1);
    step();
    chk("wrap_tmr_0", tmr_a, 1'b0);
    access(0, 0, A_MTIME, 0, rd, er);
    chk("wrap_mtime", rd, 64'd1);
    step();

    // 5: error decode and back-to-back requests
    access(0, 0, 16'h0004, 0, rd, er);
    chk("err_0004", er, 1'b1);
    chk("err_0004_rdata", rd, 64'd0);
    step();
    access(0, 0, 16'h1000, 0, rd, er);
    chk("err_1000", er, 1'b1);
    chk("err_1000_rdata", rd, 64'd0);
    step();
    access(0, 1, 16'h4004, 64'd0, rd, er);
    chk("err_wr_4004", er, 1'b1);
    step();
    access(0, 0, A_CMP, 0, rd, er);
    chk("cmp_unchanged", rd, ONES);
    chk("cmp_read_err", er, 1'b0);
    step();
    chk("rdata_hold", rdata_a, ONES);
    req_a = 1'b1; we_a = 1'b0; addr_a = A_MTIME;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("b2b_ack_%0d", i), ack_a, (i % 2 == 0) ? 1'b1 : 1'b0);
    end
    req_a = 1'b0;

    // 6: MTIME_DIV=4 prescaler, halt, reset during RESP
    access(1, 1, A_MTIME, 64'd0, rd, er);
    repeat (8) step();
    access(1, 0, A_MTIME, 0, rd, er);
    chk("div4_mtime_2", rd, 64'd2);
    repeat (3) step();
    access(1, 0, A_MTIME, 0, rd, er);
    chk("div4_mtime_3", rd, 64'd3);
`ifdef CLINT_TIMER_HALT_EN
    halt_b = 1'b1;
    repeat (7) step();
    access(1, 0, A_MTIME, 0, rd, er);
    chk("halt_mtime", rd, 64'd3);
    halt_b = 1'b0;
`endif
    step();
    access(1, 1, A_CMP, 64'd5, rd, er);
    rst = 1'b1;
    step();
    chk("rstresp_ack", ack_b, 1'b0);
    chk("rstresp_err", err_b, 1'b0);
    chk("rstresp_rdata", rdata_b, 64'd0);
    chk("rstresp_tmr", tmr_b, 1'b0);
    chk("rstresp_sft", sft_b, 1'b0);
    req_a = 1'b1; we_a = 1'b1; addr_a = A_MSIP; wdata_a = 64'h1;
    step();
    chk("rstreq_ack", ack_a, 1'b0);
    req_a = 1'b0;
    rst = 1'b0;
    step();
    step();
    chk("rstreq_sft", sft_a, 1'b0);
    access(1, 0, A_CMP, 0, rd, er);
    chk("rst_cmp_b", rd, ONES);
    step();
    access(0, 0, A_MSIP, 0, rd, er);
    chk("rst_msip_a", rd, 64'd0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
